// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotates a single low column drive, synchronises and debounces the rows,
// and holds the accepted key as active-low column/row codes until its release is debounced.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_c,
    output logic [3:0] key_r,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_sync;
    logic [3:0]    r_row_s;
    logic [3:0]    r_col_out;
    logic [3:0]    r_cap_c;
    logic [3:0]    r_cap_r;
    logic [3:0]    r_key_c;
    logic [3:0]    r_key_r;
    logic          r_key_valid;
    logic          r_key_held;

    logic          w_sample;
    logic          w_one_low;
    logic          w_idle;
    logic [3:0]    w_col_next;

    // Only a single low row is a usable key; two or more low rows may be ghosting.
    always_comb begin
        w_one_low = 1'b0;
        case (r_row_s)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_one_low = 1'b1;
            default:                            w_one_low = 1'b0;
        endcase
    end

    assign w_sample   = (r_div == DIV_LAST);
    assign w_idle     = (r_row_s == 4'b1111);
    assign w_col_next = {r_col_out[2:0], r_col_out[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_SCAN;
            r_div       <= '0;
            r_cnt       <= '0;
            r_sync      <= 4'b1111;
            r_row_s     <= 4'b1111;
            r_col_out   <= 4'b1110;
            r_cap_c     <= 4'b1111;
            r_cap_r     <= 4'b1111;
            r_key_c     <= 4'b1111;
            r_key_r     <= 4'b1111;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_sync      <= row_in;
            r_row_s     <= r_sync;
            r_div       <= w_sample ? '0 : r_div + 1'b1;
            r_key_valid <= 1'b0;
            if (w_sample) begin
                case (r_state)
                    S_SCAN: begin
                        if (w_one_low) begin
                            r_cap_r <= r_row_s;
                            r_cap_c <= r_col_out;
                            if (DEBOUNCE == 1) begin
                                r_key_c     <= r_col_out;
                                r_key_r     <= r_row_s;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= S_HELD;
                            end else begin
                                r_cnt   <= CW'(1);
                                r_state <= S_DEBOUNCE;
                            end
                        end else begin
                            r_col_out <= w_col_next;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (r_row_s == r_cap_r) begin
                            if (r_cnt == CNT_LAST) begin
                                r_key_c     <= r_cap_c;
                                r_key_r     <= r_cap_r;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= S_HELD;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_cnt     <= '0;
                            r_col_out <= w_col_next;
                            r_state   <= S_SCAN;
                        end
                    end
                    S_HELD: begin
                        // Any non-idle sample, including a second row in this column, restarts release.
                        if (w_idle) begin
                            if (r_cnt == CNT_LAST) begin
                                r_key_c    <= 4'b1111;
                                r_key_r    <= 4'b1111;
                                r_key_held <= 1'b0;
                                r_cnt      <= '0;
                                r_col_out  <= w_col_next;
                                r_state    <= S_SCAN;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= S_SCAN;
                    end
                endcase
            end
        end
    end

    assign col_out   = r_col_out;
    assign key_c     = r_key_c;
    assign key_r     = r_key_r;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated keypad matrix, per-cycle reference model, directed scenarios.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_c;
    logic [3:0] key_r;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_c    (key_c),
        .key_r    (key_r),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_pulse = 0;

    // pressed[col][row]
    logic pressed [4][4];

    always_comb begin
        row_in = 4'b1111;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                if (pressed[j][i] && col_out[j] == 1'b0) row_in[i] = 1'b0;
    end

    // Reference model: sample every SCAN_DIV clocks, count qualifying samples per mode.
    int         m_div = 0;
    int         m_col = 0;
    int         m_mode = 0;   // 0 scanning, 1 confirming press, 2 key held
    int         m_cnt = 0;
    logic [3:0] m_s1 = 4'hF;
    logic [3:0] m_s2 = 4'hF;
    logic [3:0] m_rs;
    logic [3:0] m_capr = 4'hF;
    logic [3:0] m_capc = 4'hF;
    logic [3:0] m_kc = 4'hF;
    logic [3:0] m_kr = 4'hF;
    logic       m_v = 1'b0;
    logic       m_h = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_div = 0; m_col = 0; m_mode = 0; m_cnt = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_capr = 4'hF; m_capc = 4'hF;
            m_kc = 4'hF; m_kr = 4'hF; m_v = 1'b0; m_h = 1'b0;
        end else begin
            m_rs = m_s2;
            m_s2 = m_s1;
            m_s1 = row_in;
            m_v  = 1'b0;
            if (m_div == SCAN_DIV - 1) begin
                if (m_mode == 0) begin
                    if ($countones(~m_rs) == 1) begin
                        m_capr = m_rs;
                        m_capc = ~(4'b0001 << m_col);
                        m_cnt  = 1;
                        m_mode = 1;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end else if (m_mode == 1) begin
                    if (m_rs == m_capr) m_cnt++;
                    else begin
                        m_cnt = 0; m_col = (m_col + 1) % 4; m_mode = 0;
                    end
                end else begin
                    if (m_rs == 4'hF) m_cnt++;
                    else m_cnt = 0;
                    if (m_cnt == DEBOUNCE) begin
                        m_kc = 4'hF; m_kr = 4'hF; m_h = 1'b0;
                        m_cnt = 0; m_col = (m_col + 1) % 4; m_mode = 0;
                    end
                end
                if (m_mode == 1 && m_cnt == DEBOUNCE) begin
                    m_kc = m_capc; m_kr = m_capr; m_v = 1'b1; m_h = 1'b1;
                    m_cnt = 0; m_mode = 2;
                end
            end
            m_div = (m_div + 1) % SCAN_DIV;
        end
    end

    function automatic logic [13:0] dut_pack();
        return {col_out, key_c, key_r, key_valid, key_held};
    endfunction

    always @(negedge clk) begin
        logic [13:0] exp_v;
        exp_v = {~(4'b0001 << m_col), m_kc, m_kr, m_v, m_h};
        total++;
        if (dut_pack() !== exp_v) begin
            bad++;
            $display("FAIL model_cmp t=%0t got col/c/r/v/h=%b want %b", $time, dut_pack(), exp_v);
        end
        if (key_valid === 1'b1) n_pulse++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_out(input string nm, input logic [13:0] expv);
        total++;
        if (dut_pack() !== expv) begin
            bad++;
            $display("FAIL %s: got col/c/r/v/h=%b want %b", nm, dut_pack(), expv);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic clear_keys();
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) pressed[j][i] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_valid(input string nm, input int lim);
        int w;
        w = 0;
        while (key_valid !== 1'b1 && w < lim) begin
            tick();
            w++;
        end
        check_int(nm, int'(w < lim), 1);
    endtask

    task automatic wait_release(input string nm, input int lim);
        int w;
        w = 0;
        while (key_held !== 1'b0 && w < lim) begin
            tick();
            w++;
        end
        check_int(nm, int'(w < lim), 1);
    endtask

    initial begin
        int n0;
        clear_keys();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check_out("reset_state", {4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b0});

        // Idle scan after release
        reset = 1'b0;
        cyc = 0;
        n0 = n_pulse;
        ticks(3);  check_out("idle_c3",  {4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b0});
        ticks(1);  check_out("idle_c4",  {4'b1101, 4'b1111, 4'b1111, 1'b0, 1'b0});
        ticks(4);  check_out("idle_c8",  {4'b1011, 4'b1111, 4'b1111, 1'b0, 1'b0});
        ticks(4);  check_out("idle_c12", {4'b0111, 4'b1111, 4'b1111, 1'b0, 1'b0});
        ticks(4);  check_out("idle_c16", {4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b0});
        check_int("idle_pulses", n_pulse - n0, 0);

        // Single press held from reset release, then release
        pressed[0][0] = 1'b1;
        do_reset(5);
        n0 = n_pulse;
        ticks(11); check_out("press_c11", {4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b0});
        tick();    check_out("press_c12", {4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b1});
        tick();    check_out("press_c13", {4'b1110, 4'b1110, 4'b1110, 1'b0, 1'b1});
        ticks(25);
        pressed[0][0] = 1'b0;
        check_int("press_pulses", n_pulse - n0, 1);
        ticks(13); check_out("rel_c51", {4'b1110, 4'b1110, 4'b1110, 1'b0, 1'b1});
        tick();    check_out("rel_c52", {4'b1101, 4'b1111, 4'b1111, 1'b0, 1'b0});

        // Bouncing key at column 2 / row 3
        clear_keys();
        do_reset(2);
        n0 = n_pulse;
        for (int k = 0; k < 8; k++) begin
            pressed[2][3] = (k % 2 == 0);
            ticks(5);
        end
        check_int("bounce_quiet", n_pulse - n0, 0);
        pressed[2][3] = 1'b1;
        wait_valid("bounce_wait", 200);
        check_out("bounce_accept", {4'b1011, 4'b1011, 4'b0111, 1'b1, 1'b1});
        ticks(40);
        check_int("bounce_pulses", n_pulse - n0, 1);
        clear_keys();
        wait_release("bounce_release", 100);

        // Two rows low in column 1 must never be accepted
        clear_keys();
        do_reset(2);
        n0 = n_pulse;
        pressed[1][0] = 1'b1;
        pressed[1][1] = 1'b1;
        ticks(60);
        check_out("ghost_c60", {4'b0111, 4'b1111, 4'b1111, 1'b0, 1'b0});
        check_int("ghost_pulses", n_pulse - n0, 0);
        clear_keys();
        ticks(4);

        // Extra row in the held column is ignored
        pressed[1][1] = 1'b1;
        wait_valid("hold_wait", 100);
        check_out("hold_accept", {4'b1101, 4'b1101, 4'b1101, 1'b1, 1'b1});
        n0 = n_pulse;
        pressed[1][2] = 1'b1;
        ticks(40);
        check_out("hold_change", {4'b1101, 4'b1101, 4'b1101, 1'b0, 1'b1});
        check_int("hold_pulses", n_pulse - n0, 0);
        clear_keys();
        wait_release("hold_release", 100);
        check_out("hold_released", {4'b1011, 4'b1111, 4'b1111, 1'b0, 1'b0});

        // Reset during debounce, then the same press re-accepted
        clear_keys();
        pressed[0][0] = 1'b1;
        do_reset(2);
        ticks(9);
        reset = 1'b1;
        #1;
        check_out("midrst_now", {4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        #1;
        check_out("midrst_hold", {4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b0});
        reset = 1'b0;
        cyc = 0;
        n0 = n_pulse;
        ticks(11); check_out("midrst_c11", {4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b0});
        tick();    check_out("midrst_c12", {4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b1});
        ticks(5);
        check_int("midrst_pulses", n_pulse - n0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad scanner for the vending machine: drives the 4 keypad column lines, samples the 4 row lines, debounces, and presents the pressed key as the active-low column/row code pair that the vending FSM consumes on its `c`/`r` inputs. It sits between the board keypad pins and `finite_state`. It replaces the direct `c`/`r` stimulus with a real scan of the keypad.

## Interface
- `SCAN_DIV`, default 4: clocks per column window. Must be ≥ 3.
- `DEBOUNCE`, default 3: consecutive matching samples needed to accept a press, and consecutive idle samples needed to accept a release. Must be ≥ 1.
- `clk`  in  1  system clock; the block has one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `row_in`  in  4  keypad rows. Active-low, pulled up; `1111` = nothing pressed. Asynchronous to `clk`.
- `col_out`  out  4  column drive. Exactly one bit is low at any time.
- `key_c`  out  4  accepted key column code. Active-low one-hot-low; `1111` when no key is accepted. Connects to the FSM `c` input.
- `key_r`  out  4  accepted key row code. Same encoding as `key_c`. Connects to the FSM `r` input.
- `key_valid`  out  1  one-clock pulse when a press is accepted.
- `key_held`  out  1  high from press acceptance until release acceptance.

## Operation
- `row_in` passes through a 2-flop synchronizer (`row_s`), which resets to `1111`. All decisions use `row_s`.
- Divider `div` counts 0..`SCAN_DIV`-1 continuously. A sample event occurs when `div == SCAN_DIV-1`.
- Column index `col` runs 0..3, and `col_out = ~(1 << col)`.
- Reset values: `col = 0` (so `col_out = 1110`), `div = 0`, `key_c = key_r = 1111`, `key_valid = 0`, `key_held = 0`, stable count `cnt = 0`, state SCAN.
- **SCAN**, at each sample:
  - If `row_s` has exactly one zero bit: capture `cap_r = row_s` and `cap_c = col_out`, set `cnt = 1`, go to DEBOUNCE. `col` does not advance.
  - Otherwise (`1111`, or two or more rows low, i.e. ghost/multi-press): `col` advances, wrapping 3→0.
- **DEBOUNCE**: `col` is frozen. At each sample:
  - If `row_s == cap_r`, then `cnt++`.
  - When `cnt` reaches `DEBOUNCE`, on the next edge: `key_c = cap_c`, `key_r = cap_r`, `key_valid = 1` for one cycle, `key_held = 1`, go to HELD.
  - If `row_s` differs from `cap_r`, set `cnt = 0`, advance `col`, and return to SCAN.
  - With `DEBOUNCE == 1`, the detection sample itself accepts the press.
- **HELD**: `col` is frozen and the outputs are held. At each sample:
  - If `row_s == 1111`, then `cnt++`; any other value sets `cnt = 0`.
  - A different row in the same column while held is ignored, with no new `key_valid`.
  - When `cnt` reaches `DEBOUNCE`, on the next edge: `key_c = key_r = 1111`, `key_held = 0`, advance `col`, go to SCAN.
- `key_valid` never asserts twice for one press. There is no auto-repeat.
- `key_c`/`key_r` change only on press acceptance and release acceptance.

## Timing
- The synchronizer adds 2 cycles of latency. `SCAN_DIV ≥ 3` guarantees the rows have settled for the current column before its sample.
- Sample events fall at clocks `SCAN_DIV-1`, `2·SCAN_DIV-1`, … after reset deassertion.
- Press acceptance: `key_valid`, `key_c`, `key_r` and `key_held` all update on the same edge, one clock after the `DEBOUNCE`-th matching sample.
- Best-case press latency (key already down on the driven column) is `DEBOUNCE·SCAN_DIV` clocks. Worst case adds 3 column windows of scanning.
- Release latency is `DEBOUNCE·SCAN_DIV` clocks after `row_s` returns to `1111`, plus up to one window of alignment.
- Reset asserted mid-operation, in any state: all outputs return to their reset values immediately (asynchronously). No `key_valid` is emitted for an interrupted debounce.
- The divider never pauses. State changes take effect at sample boundaries only.

## Test plan
The bench models the keypad as: `row_in[i] = 0` iff the key at (column `j`, row `i`) is pressed and `col_out[j] == 0`. Parameters are at their defaults.
- **Reset/idle:** hold `reset` for 5 clocks, then release with no key pressed → `col_out` cycles `1110`→`1101`→`1011`→`0111`→`1110`, changing every 4 clocks. `key_c = key_r = 1111`. `key_valid` is never high.
- **Single press:** key (c=`1110`, r=`1110`) held from reset release → exactly one `key_valid` pulse, at the 12th clock after release. Then `key_c = 1110`, `key_r = 1110`, `key_held = 1`, and `col_out` stays `1110`.
- **Release:** from the single-press case, release the key → 12 clocks after `row_s` reads `1111`, `key_held = 0` and `key_c = key_r = 1111`. Scanning resumes with `col_out = 1101`.
- **Bounce:** key (c=`1011`, r=`0111`) toggled every 5 clocks for 40 clocks, then held → no `key_valid` during bouncing. Exactly one pulse after it becomes stable, with `key_c = 1011` and `key_r = 0111`.
- **Ghost/multi and held-change:** rows `1110` and `1101` pressed together in column 1 → no acceptance. Separately, while (`1101`, `1101`) is held, add row `1011` in the same column → no second `key_valid` and outputs unchanged.
- **Reset mid-debounce:** assert `reset` after 2 matching samples → `key_valid` stays 0 and `col_out = 1110` immediately. After release, the press is re-accepted at the 12th clock.
